// File: rtl/sync_debounce_cdc.sv
// Per-channel synchronizer and debounce filter. Optional rise/fall pulses under SYNC_DEBOUNCE_EDGE_EN.
// q updates STAGES+FILT edges after a stable input change. rise/fall follow one cycle after the load. No backpressure.
module sync_debounce_cdc #(
  parameter int               WIDTH  = 4,
  parameter int               STAGES = 2,
  parameter int               FILT   = 3,
  parameter logic [WIDTH-1:0] INIT   = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [WIDTH-1:0] busy
);

  localparam logic [7:0] LAST = 8'(FILT - 1);

  logic [WIDTH-1:0] chain [STAGES];
  logic [WIDTH-1:0] s;
  logic [7:0]       cnt [WIDTH];
  logic [WIDTH-1:0] load;

  // Plain flop chain: no logic between stages so each stage resolves metastability.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) chain[k] <= INIT;
    end else begin
      chain[0] <= d;
      for (int k = 1; k < STAGES; k++) chain[k] <= chain[k-1];
    end
  end

  assign s = chain[STAGES-1];

  always_comb begin
    load = '0;
    busy = '0;
    for (int i = 0; i < WIDTH; i++) begin
      load[i] = (s[i] != q[i]) && (cnt[i] == LAST);
      busy[i] = (cnt[i] != 8'd0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= INIT;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= 8'd0;
    end else begin
      q <= q ^ load;
      for (int i = 0; i < WIDTH; i++) begin
        if ((s[i] == q[i]) || load[i]) cnt[i] <= 8'd0;
        else                           cnt[i] <= cnt[i] + 8'd1;
      end
    end
  end

`ifdef SYNC_DEBOUNCE_EDGE_EN
  // Pulses come from the load strobe, so reset itself can never create one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rise <= '0;
      fall <= '0;
    end else begin
      rise <= load & s;
      fall <= load & ~s;
    end
  end
`else
  assign rise = '0;
  assign fall = '0;
`endif

endmodule
